// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window on the core bus,
// a TX FIFO and a serialiser with a programmable bit divider.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        tx
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
   localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW:0]   count;
   logic            overflow;
   logic [15:0]     bauddiv;
   logic [15:0]     div_l;
   logic [15:0]     timer;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;

   logic        wr_en;
   logic        push;
   logic        push_ok;
   logic        pop;
   logic        status_wr;
   logic        baud_wr;
   logic        full;
   logic        empty;
   logic        busy;
   logic        bit_done;
   logic [7:0]  head;
   logic [15:0] div_next;
   logic [31:0] status;
   logic [31:0] reg_rdata;
   logic        unused_bits;

   assign sel       = (address[31:4] == BASE_ADDR[31:4]);
   assign wr_en     = we & sel;
   assign push      = wr_en & (address[3:2] == 2'd0);
   assign status_wr = wr_en & (address[3:2] == 2'd1);
   assign baud_wr   = wr_en & (address[3:2] == 2'd2);

   assign full     = (count == CountFull);
   assign empty    = (count == '0);
   assign busy     = (state != StIdle);
   assign push_ok  = push & ~full;
   assign bit_done = (timer == div_l - 16'd1);
   // Pop happens when leaving IDLE or at the end of a stop bit, so frames run back to back.
   assign pop      = ~empty & ((state == StIdle) | ((state == StStop) & bit_done));
   assign head     = fifo_mem[rd_ptr];
   assign div_next = (bauddiv == 16'd0) ? 16'd1 : bauddiv;

   assign unused_bits = ^{address[1:0], wdata[31:16]};

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= wdata[7:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PtrOne;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrOne;
         end
         if (push_ok && !pop) begin
            count <= count + CountOne;
         end else if (!push_ok && pop) begin
            count <= count - CountOne;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow <= 1'b0;
         bauddiv  <= 16'(CLKS_PER_BIT);
      end else begin
         // A dropped push outranks a software clear on the same edge.
         if (push && full) begin
            overflow <= 1'b1;
         end else if (status_wr && wdata[3]) begin
            overflow <= 1'b0;
         end
         if (baud_wr) begin
            bauddiv <= wdata[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= StIdle;
         tx      <= 1'b1;
         timer   <= '0;
         div_l   <= 16'd1;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               tx <= 1'b1;
               if (pop) begin
                  shift <= head;
                  div_l <= div_next;
                  timer <= '0;
                  tx    <= 1'b0;
                  state <= StStart;
               end
            end
            StStart: begin
               if (bit_done) begin
                  timer   <= '0;
                  tx      <= shift[0];
                  bit_idx <= '0;
                  state   <= StData;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            StData: begin
               if (bit_done) begin
                  timer <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= StStop;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            StStop: begin
               if (bit_done) begin
                  timer <= '0;
                  if (pop) begin
                     shift <= head;
                     div_l <= div_next;
                     tx    <= 1'b0;
                     state <= StStart;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      status                 = '0;
      status[0]              = full;
      status[1]              = empty;
      status[2]              = busy;
      status[3]              = overflow;
      status[8 +: PtrW + 1]  = count;

      reg_rdata = '0;
      case (address[3:2])
         2'd1:    reg_rdata = status;
         2'd2:    reg_rdata = {16'd0, bauddiv};
         default: reg_rdata = '0;
      endcase

      rdata = sel ? reg_rdata : '0;
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter attached directly downstream of the core's data bus (address / data_out / data_in / we).
- Decodes a 16-byte window, queues written bytes in a TX FIFO, and serialises them as 8N1 on `tx`.
- Returns status and config on reads so software can poll before writing.
- Read data is combinational, because the core samples data_in in the same cycle it drives address.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the register window; must be 16-byte aligned.
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, range 2..256.
- CLKS_PER_BIT, 434, reset value of BAUDDIV (50 MHz / 115200).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- address  in  32  byte address from the core.
- wdata  in  32  write data (core data_out).
- we  in  1  write enable from the core.
- rdata  out  32  read data; 0 when sel=0.
- sel  out  1  address[31:4] == BASE_ADDR[31:4]; combinational.
- tx  out  1  serial output, idle high.

Behaviour:
- Decode uses address[3:2]; address[1:0] ignored.
- Registers:
  - 0x0 TXDATA. Write pushes wdata[7:0]. Read returns 0.
  - 0x4 STATUS, read-only fields:
    - bit0 full (count==FIFO_DEPTH)
    - bit1 empty
    - bit2 busy (FSM != IDLE)
    - bit3 overflow (sticky)
    - [16:8] count
    - other bits 0
  - 0x4 STATUS write: wdata[3]=1 clears overflow; other bits ignored.
  - 0x8 BAUDDIV: [15:0] read/write; upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Write acceptance: a write is performed on every rising edge where we=1 and sel=1. A core holding we for k cycles produces k pushes. This is intentional, and software/core must assert we for exactly one cycle.
- FIFO behaviour:
  - Full is judged on the pre-edge count. A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is FIFO_DEPTH_LOG2+1 bits.
- Overflow set and clear on the same edge: set wins.
- FSM states IDLE, START, DATA, STOP. tx is registered.
  - IDLE:
    - tx=1.
    - If the FIFO is non-empty (pre-edge): pop the head into the shift register, latch div_l = max(BAUDDIV,1), clear the bit timer, set tx=0, go to START.
  - START: after div_l cycles, set tx=shift[0], bit index=0, go to DATA.
  - DATA:
    - Every div_l cycles: shift right and increment the index.
    - After bit 7 completes: set tx=1, go to STOP.
  - STOP: after div_l cycles:
    - If the FIFO is non-empty: pop, set tx=0, go to START (no idle gap).
    - Otherwise: tx stays 1, go to IDLE.
- Frame length is exactly 10*div_l cycles from the start-bit edge to the next start-bit edge in back-to-back traffic.
- Latency: write at edge N makes empty=0 after N; pop and tx falling edge occur at N+1.
- BAUDDIV writes mid-frame do not affect the current frame; they take effect at the next pop. BAUDDIV=0 behaves as 1.
- Reset values and reset mid-operation:
  - Asserting resetn=0 asynchronously forces tx=1, FSM=IDLE, FIFO empty (contents discarded), overflow=0, BAUDDIV=CLKS_PER_BIT.
  - sel/rdata stay combinational: rdata=0 whenever sel=0.
  - A frame in flight is truncated.
  - After release, the first transmission requires a new write.

Test Plan:
- Reset, BAUDDIV=4, write 0x55 to TXDATA once.
  - tx falls 1 cycle after the write edge.
  - Bits sampled mid-bit read 0,1,0,1,0,1,0,1,0 followed by a stop bit 1.
  - 40 cycles total.
  - busy=1 during the frame, then STATUS reads 0x0000_0002.
- BAUDDIV=4, write 0xA5 then 0x3C on consecutive bus writes.
  - Second start bit begins exactly 40 cycles after the first.
  - tx never goes high between the two stop/start bits.
- BAUDDIV=1000 (FSM stalls), FIFO_DEPTH=16: write 18 bytes 0x00..0x11 back-to-back.
  - First byte is popped, 16 queued, 1 dropped.
  - STATUS shows full=1, overflow=1, count=16.
  - Writing STATUS with 0x8 clears overflow only.
- Hold we=1 for 3 cycles at TXDATA with wdata=0x41.
  - Three pushes occur: count reaches 2 after one is popped.
  - Three 0x41 frames are transmitted.
- Reads:
  - Address BASE_ADDR+8 after reset returns 434.
  - Address BASE_ADDR+0xC returns 0.
  - Address BASE_ADDR+0x10 gives sel=0, rdata=0.
  - A write to BASE_ADDR+0x10 does not change count.
- Mid-frame, at data bit 3, assert resetn=0 asynchronously between edges.
  - tx=1 immediately.
  - STATUS reads 0x0000_0002 after release.
  - tx stays 1 with no further output.
